read_buffer: RTL and testbench
==============================

# read_buffer

Read-side counterpart of the write buffer on the CCI cache-line interface. Accepts 32-bit word reads and full-line direct reads from the core, holds the most recently fetched cache line for word hits, and issues tagged cache-line read requests with a single outstanding miss. Sits between the core datapath and the CCI read request/response channels.

## Interface

- ADDR_LMT, 20, cache-line address width
- MDATA, 14, request tag width
- CACHE_WIDTH, 512, cache-line width in bits
- DATA_WIDTH, 32, word width; 16 words per line

- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- rd_req_addr  out  ADDR_LMT  line address of read request
- rd_req_mdata  out  MDATA  request tag
- rd_req_en  out  1  request strobe, one cycle per request
- rd_req_almostfull  in  1  request channel cannot accept
- rd_rsp_valid  in  1  read response strobe
- rd_rsp_mdata  in  MDATA  response tag
- rd_rsp_data  in  CACHE_WIDTH  response line data
- start  in  1  leave IDLE, begin operation
- rd_en  in  1  core read request; sampled only when rd_ready=1
- rd_addr  in  ADDR_LMT+4  word address: [ADDR_LMT+3:4] line, [3:0] word offset
- rd_direct  in  1  full-line read, bypasses line holder
- rd_flush  in  1  invalidate held line
- rd_ready  out  1  block accepts rd_en this cycle
- rd_valid  out  1  rd_data valid, one-cycle pulse
- rd_data  out  CACHE_WIDTH  word in [31:0] (upper bits 0) or full line if direct

## Operation

- States: IDLE, READY, REQ, WAIT. Reset -> IDLE; all outputs 0, line_valid=0, tag counter=0.
- IDLE: rd_ready=0. start -> READY, line_valid cleared.
- READY: rd_ready=1. On rd_en:
  - hit (!rd_direct, line_valid, rd_addr line == held line tag): rd_data[31:0] = line[offset*32 +: 32], rest 0; rd_valid pulses; stay READY.
  - otherwise miss: latch line address, offset, direct flag -> REQ.
- REQ: if !rd_req_almostfull: present rd_req_addr = latched line, rd_req_mdata = tag counter, rd_req_en pulse; record outstanding tag; increment counter (mod 2^MDATA) -> WAIT. Else hold in REQ, no request.
- WAIT: rd_rsp_valid with rd_rsp_mdata == outstanding tag: deliver (word extracted from rd_rsp_data, or full line if direct); rd_valid pulse -> READY. Non-direct fill loads line and tag; line_valid=1 unless rd_flush was seen during this WAIT. Direct fill leaves held line untouched. Responses with non-matching tag or arriving outside WAIT are ignored.
- rd_flush: clears line_valid in any state. Same cycle as rd_en in READY: flush wins, read treated as miss.
- rd_en while rd_ready=0 is ignored, not queued.
- Undefined state encodings -> IDLE.
- Reset mid-miss: returns to IDLE; later response is dropped (state not WAIT).

## Timing

- All outputs registered.
- Hit: rd_en at cycle T -> rd_valid, rd_data at T+1.
- Miss: rd_en at T -> REQ at T+1; rd_req_en high at T+2 if rd_req_almostfull low at T+1; each almostfull cycle adds one.
- Response at cycle R -> rd_valid at R+1; rd_ready high from R+1.
- rd_ready low from T+1 of a miss until its rd_valid cycle.
- rd_data holds last delivered value between pulses; rd_req_addr/mdata hold between requests.
- Back-to-back hits: one per cycle.

## Test plan

- Reset, start, rd_en addr 0x00015 (line 1, word 5), rsp tag 0 with word5=0xDEADBEEF -> rd_req_en once, addr 1, mdata 0; rd_valid one cycle after rsp, rd_data=0x00000000_DEADBEEF.
- Then rd_en addr 0x0001F -> hit, no request, rd_valid at T+1 with word 15 of same line; 16 consecutive hits one per cycle.
- rd_direct to line 7 with almostfull high 3 cycles -> request issued 3 cycles late, mdata 1; full 512-bit line returned; next word read of line 1 still hits.
- In WAIT, inject rsp tag mismatch, then matching tag -> first ignored, rd_valid only after second.
- rd_flush with rd_en same cycle on held line -> miss issued; flush during WAIT -> next read same line misses again.
- Tag wrap: MDATA=2, 5 misses -> mdata 0,1,2,3,0; reset during WAIT then late rsp -> no rd_valid, outputs 0.

Source files
------------

// File: rtl/read_buffer.sv
// read_buffer: read-side cache-line buffer on the CCI interface.
// Serves 32-bit word hits from the last fetched line, issues one tagged
// line read at a time on a miss, and supports full-line direct reads.
module read_buffer #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_LMT-1:0]    rd_req_addr,
  output logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_en,
  input  logic                   rd_req_almostfull,
  input  logic                   rd_rsp_valid,
  input  logic [MDATA-1:0]       rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic                   start,
  input  logic                   rd_en,
  input  logic [ADDR_LMT+3:0]    rd_addr,
  input  logic                   rd_direct,
  input  logic                   rd_flush,
  output logic                   rd_ready,
  output logic                   rd_valid,
  output logic [CACHE_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_REQ   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state, state_next;

  // Held line and its bookkeeping
  logic [CACHE_WIDTH-1:0] line_q;
  logic [ADDR_LMT-1:0]    line_tag;
  logic                   line_valid;
  logic                   flush_seen;

  // Pending miss context
  logic [ADDR_LMT-1:0]    miss_line;
  logic [3:0]             miss_off;
  logic                   miss_direct;

  // Request tagging
  logic [MDATA-1:0]       tag_cnt;
  logic [MDATA-1:0]       out_tag;

  logic [ADDR_LMT-1:0]    req_line;
  logic [3:0]             req_off;
  logic                   hit;
  logic                   take_miss;
  logic                   issue;
  logic                   rsp_hit;
  logic [DATA_WIDTH-1:0]  hit_word;
  logic [DATA_WIDTH-1:0]  rsp_word;

  assign req_line = rd_addr[ADDR_LMT+3:4];
  assign req_off  = rd_addr[3:0];
  assign hit_word = line_q[req_off*DATA_WIDTH +: DATA_WIDTH];
  assign rsp_word = rd_rsp_data[miss_off*DATA_WIDTH +: DATA_WIDTH];

  // Event decode; a flush in the same cycle as a read forces a miss
  always_comb begin
    hit       = 1'b0;
    take_miss = 1'b0;
    issue     = 1'b0;
    rsp_hit   = 1'b0;
    if (state == S_READY && rd_en) begin
      hit       = !rd_direct && !rd_flush && line_valid && (req_line == line_tag);
      take_miss = !hit;
    end
    if (state == S_REQ)
      issue = !rd_req_almostfull;
    if (state == S_WAIT)
      rsp_hit = rd_rsp_valid && (rd_rsp_mdata == out_tag);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)     state_next = S_READY;
      S_READY: if (take_miss) state_next = S_REQ;
      S_REQ:   if (issue)     state_next = S_WAIT;
      S_WAIT:  if (rsp_hit)   state_next = S_READY;
      default:                state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Registered outputs, line holder and miss tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      rd_req_en    <= 1'b0;
      rd_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      line_q       <= '0;
      line_tag     <= '0;
      line_valid   <= 1'b0;
      flush_seen   <= 1'b0;
      miss_line    <= '0;
      miss_off     <= '0;
      miss_direct  <= 1'b0;
      tag_cnt      <= '0;
      out_tag      <= '0;
    end else begin
      rd_valid  <= 1'b0;
      rd_req_en <= 1'b0;
      rd_ready  <= (state_next == S_READY);

      if (state == S_IDLE && start)
        line_valid <= 1'b0;

      if (hit) begin
        rd_valid <= 1'b1;
        rd_data  <= {{(CACHE_WIDTH-DATA_WIDTH){1'b0}}, hit_word};
      end

      if (take_miss) begin
        miss_line   <= req_line;
        miss_off    <= req_off;
        miss_direct <= rd_direct;
      end

      if (issue) begin
        rd_req_en    <= 1'b1;
        rd_req_addr  <= miss_line;
        rd_req_mdata <= tag_cnt;
        out_tag      <= tag_cnt;
        tag_cnt      <= tag_cnt + 1'b1;
        flush_seen   <= 1'b0;
      end

      if (state == S_WAIT && rd_flush)
        flush_seen <= 1'b1;

      if (rsp_hit) begin
        rd_valid <= 1'b1;
        if (miss_direct) begin
          rd_data <= rd_rsp_data;
        end else begin
          rd_data    <= {{(CACHE_WIDTH-DATA_WIDTH){1'b0}}, rsp_word};
          line_q     <= rd_rsp_data;
          line_tag   <= miss_line;
          line_valid <= !(flush_seen || rd_flush);
        end
      end

      // Flush overrides any fill or restart in the same cycle
      if (rd_flush)
        line_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_buffer.sv
// tb_read_buffer: directed vector table plus multi-cycle corner sequences.
module tb_read_buffer;

  localparam int AL = 20;
  localparam int MD = 2;
  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] rd_req_addr;
  logic [MD-1:0] rd_req_mdata;
  logic          rd_req_en;
  logic          rd_req_almostfull;
  logic          rd_rsp_valid;
  logic [MD-1:0] rd_rsp_mdata;
  logic [CW-1:0] rd_rsp_data;
  logic          start;
  logic          rd_en;
  logic [AL+3:0] rd_addr;
  logic          rd_direct;
  logic          rd_flush;
  logic          rd_ready;
  logic          rd_valid;
  logic [CW-1:0] rd_data;

  int unsigned errors = 0;
  int unsigned checks = 0;

  read_buffer #(
    .ADDR_LMT(AL),
    .MDATA(MD),
    .CACHE_WIDTH(CW),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata),
    .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data),
    .start(start),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_direct(rd_direct),
    .rd_flush(rd_flush),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Line contents: word i of line la = C0_<la[15:0]>_0<i>, line 1 word 5 = DEADBEEF
  function automatic logic [CW-1:0] mk_line(input logic [AL-1:0] la);
    logic [CW-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < 16; i++)
      l[i*32 +: 32] = {8'hC0, la[15:0], 4'h0, 4'(i)};
    if (la == 20'd1)
      l[5*32 +: 32] = 32'hDEADBEEF;
    return l;
  endfunction

  function automatic logic [CW-1:0] exp_word(input logic [AL-1:0] la, input logic [3:0] off);
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    l = mk_line(la);
    r = '0;
    r[31:0] = l[off*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic en, input logic [AL+3:0] addr,
                       input logic dir, input logic fl, input logic af, input logic rv,
                       input logic [MD-1:0] rtag, input logic [AL-1:0] rline);
    rst               = r;
    start             = st;
    rd_en             = en;
    rd_addr           = addr;
    rd_direct         = dir;
    rd_flush          = fl;
    rd_req_almostfull = af;
    rd_rsp_valid      = rv;
    rd_rsp_mdata      = rtag;
    rd_rsp_data       = mk_line(rline);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          start, en;
    logic [AL+3:0] addr;
    logic          direct, af, rv;
    logic [MD-1:0] rtag;
    logic [AL-1:0] rline;
    logic          e_valid, e_ready, e_req;
    logic [AL-1:0] e_raddr;
    logic [MD-1:0] e_rtag;
    logic          e_full;
    logic [AL-1:0] e_dline;
    logic [3:0]    e_off;
  } vec_t;

  function automatic vec_t v(input logic st, input logic en, input logic [AL+3:0] addr,
                             input logic dir, input logic af, input logic rv,
                             input logic [MD-1:0] rtag, input logic [AL-1:0] rline,
                             input logic ev, input logic er, input logic eq,
                             input logic [AL-1:0] eaddr, input logic [MD-1:0] etag,
                             input logic efull, input logic [AL-1:0] edline, input logic [3:0] eoff);
    vec_t t;
    t.start = st;  t.en = en;  t.addr = addr;  t.direct = dir;  t.af = af;
    t.rv = rv;  t.rtag = rtag;  t.rline = rline;
    t.e_valid = ev;  t.e_ready = er;  t.e_req = eq;  t.e_raddr = eaddr;  t.e_rtag = etag;
    t.e_full = efull;  t.e_dline = edline;  t.e_off = eoff;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    //             st en addr       dir af rv tag line   ev er eq raddr tag full dline off
    vecs.push_back(v(1, 0, 24'h00000, 0, 0, 0, 0, 20'd0, 0, 1, 0, 20'd0, 0, 0, 20'd0, 0));
    vecs.push_back(v(0, 1, 24'h00015, 0, 0, 0, 0, 20'd0, 0, 0, 0, 20'd0, 0, 0, 20'd0, 0));
    vecs.push_back(v(0, 0, 24'h00000, 0, 0, 0, 0, 20'd0, 0, 0, 1, 20'd1, 0, 0, 20'd0, 0));
    vecs.push_back(v(0, 0, 24'h00000, 0, 0, 1, 0, 20'd1, 1, 1, 0, 20'd0, 0, 0, 20'd1, 5));
    vecs.push_back(v(0, 1, 24'h0001F, 0, 0, 0, 0, 20'd0, 1, 1, 0, 20'd0, 0, 0, 20'd1, 15));
    for (int unsigned k = 0; k < 16; k++)
      vecs.push_back(v(0, 1, {20'd1, 4'(k)}, 0, 0, 0, 0, 20'd0, 1, 1, 0, 20'd0, 0, 0, 20'd1, 4'(k)));
    vecs.push_back(v(0, 0, 24'h00000, 0, 0, 0, 0, 20'd0, 0, 1, 0, 20'd0, 0, 0, 20'd0, 0));
    vecs.push_back(v(0, 1, 24'h00070, 1, 0, 0, 0, 20'd0, 0, 0, 0, 20'd0, 0, 0, 20'd0, 0));
    for (int unsigned k = 0; k < 3; k++)
      vecs.push_back(v(0, 0, 24'h00000, 0, 1, 0, 0, 20'd0, 0, 0, 0, 20'd0, 0, 0, 20'd0, 0));
    vecs.push_back(v(0, 0, 24'h00000, 0, 0, 0, 0, 20'd0, 0, 0, 1, 20'd7, 1, 0, 20'd0, 0));
    vecs.push_back(v(0, 0, 24'h00000, 0, 0, 1, 1, 20'd7, 1, 1, 0, 20'd0, 0, 1, 20'd7, 0));
    vecs.push_back(v(0, 1, 24'h00013, 0, 0, 0, 0, 20'd0, 1, 1, 0, 20'd0, 0, 0, 20'd1, 3));

    // Reset state
    drive(1, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    tick();
    chk("rst.valid", rd_valid, 0);
    chk("rst.ready", rd_ready, 0);
    chk("rst.req_en", rd_req_en, 0);
    chk("rst.req_addr", rd_req_addr, 0);
    chk("rst.req_mdata", rd_req_mdata, 0);
    chk("rst.data", rd_data, 0);

    // Vector table
    foreach (vecs[i]) begin
      drive(0, vecs[i].start, vecs[i].en, vecs[i].addr, vecs[i].direct, 0, vecs[i].af,
            vecs[i].rv, vecs[i].rtag, vecs[i].rline);
      tick();
      chk($sformatf("v%0d.valid", i), rd_valid, vecs[i].e_valid);
      chk($sformatf("v%0d.ready", i), rd_ready, vecs[i].e_ready);
      chk($sformatf("v%0d.req_en", i), rd_req_en, vecs[i].e_req);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d.req_addr", i), rd_req_addr, vecs[i].e_raddr);
        chk($sformatf("v%0d.req_mdata", i), rd_req_mdata, vecs[i].e_rtag);
      end
      if (vecs[i].e_valid)
        chk($sformatf("v%0d.data", i), rd_data,
            vecs[i].e_full ? mk_line(vecs[i].e_dline) : exp_word(vecs[i].e_dline, vecs[i].e_off));
    end

    // Mismatched response tag is ignored
    drive(0, 0, 1, 24'h00024, 0, 0, 0, 0, 0, '0);
    tick();
    chk("mm.miss_ready", rd_ready, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("mm.req_en", rd_req_en, 1);
    chk("mm.req_addr", rd_req_addr, 2);
    chk("mm.req_mdata", rd_req_mdata, 2);
    drive(0, 0, 0, '0, 0, 0, 0, 1, 3, 20'd2);
    tick();
    chk("mm.bad_tag_valid", rd_valid, 0);
    chk("mm.bad_tag_ready", rd_ready, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1, 2, 20'd2);
    tick();
    chk("mm.good_tag_valid", rd_valid, 1);
    chk("mm.good_tag_data", rd_data, exp_word(20'd2, 4));

    // Response outside WAIT is ignored
    drive(0, 0, 0, '0, 0, 0, 0, 1, 2, 20'd2);
    tick();
    chk("stray.valid", rd_valid, 0);
    chk("stray.ready", rd_ready, 1);

    // Flush together with a read of the held line forces a miss
    drive(0, 0, 1, 24'h00021, 0, 1, 0, 0, 0, '0);
    tick();
    chk("fl.miss_valid", rd_valid, 0);
    chk("fl.miss_ready", rd_ready, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("fl.req_en", rd_req_en, 1);
    chk("fl.req_mdata", rd_req_mdata, 3);
    // Flush while waiting: the fill is delivered but not kept
    drive(0, 0, 0, '0, 0, 1, 0, 0, 0, '0);
    tick();
    chk("fl.wait_valid", rd_valid, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1, 3, 20'd2);
    tick();
    chk("fl.fill_valid", rd_valid, 1);
    chk("fl.fill_data", rd_data, exp_word(20'd2, 1));
    drive(0, 0, 1, 24'h00022, 0, 0, 0, 0, 0, '0);
    tick();
    chk("fl.remiss_valid", rd_valid, 0);
    chk("fl.remiss_ready", rd_ready, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("wrap.req_en", rd_req_en, 1);
    chk("wrap.req_mdata", rd_req_mdata, 0);

    // Reset while waiting, then a late response
    drive(1, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("rw.valid", rd_valid, 0);
    chk("rw.ready", rd_ready, 0);
    chk("rw.data", rd_data, 0);
    chk("rw.req_addr", rd_req_addr, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 1, 0, 20'd2);
    tick();
    chk("late.valid", rd_valid, 0);
    chk("late.ready", rd_ready, 0);
    chk("late.data", rd_data, 0);
    drive(0, 1, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("restart.ready", rd_ready, 1);
    drive(0, 0, 1, 24'h00022, 0, 0, 0, 0, 0, '0);
    tick();
    chk("restart.miss", rd_ready, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("restart.req_en", rd_req_en, 1);
    chk("restart.req_mdata", rd_req_mdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
